reg_file_mp: RTL and testbench

//  Parametrised multi-read, dual-write register file for the multicycle MIPS datapath and its successors.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_clr_fsm.sv | 62 ++++++
 rtl/reg_file_mp.sv | 83 ++++++++
 tb/tb_reg_file_mp.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types, constants and helpers for the multi-port register file.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int unsigned ZERO_ADDR = 0;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Bulk-clear sequencer: walks registers 1..DEPTH-1, zeroing one per cycle,
// then pulses done. Request is only honoured while idle.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              CLR_BUSY,
  output logic              CLR_DONE
);

  localparam int unsigned       DEPTH     = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State, counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_we   <= 1'b0;
      CLR_BUSY <= 1'b0;
      CLR_DONE <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_we   <= (state_nxt == CLEAR);
      CLR_BUSY <= (state_nxt == CLEAR);
      CLR_DONE <= (state_nxt == DONE);
    end
  end

  // Counter saturates at the last address; it never wraps back to 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (cnt == LAST_ADDR) state_nxt = DONE;
        else                  cnt_nxt   = cnt + ADDR_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with r0 hardwired to zero and a bulk clear.
// Define REG_FILE_BYPASS_EN for write-through forwarding on every read port.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  input  logic                     WE_A,
  input  logic [ADDR_W-1:0]        WA_A,
  input  logic [DATA_W-1:0]        WD_A,
  input  logic                     WE_B,
  input  logic [ADDR_W-1:0]        WA_B,
  input  logic [DATA_W-1:0]        WD_B,
  input  logic                     CLR_REQ,
  output logic                     CLR_BUSY,
  output logic                     CLR_DONE
);

  localparam int unsigned       DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_a_ok;
  logic              wr_b_ok;

  reg_file_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (CLK),
    .rst_n    (RST),
    .clr_req  (CLR_REQ),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .CLR_BUSY (CLR_BUSY),
    .CLR_DONE (CLR_DONE)
  );

  // External writes are locked out for the whole clear sweep.
  assign wr_a_ok = WE_A && (WA_A != ZERO) && !clr_we;
  assign wr_b_ok = WE_B && (WA_B != ZERO) && !clr_we;

  // Storage: clear sweep first, then port B, then port A.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (clr_we) begin
          if (clr_addr == ADDR_W'(i)) mem[ADDR_W'(i)] <= '0;
        end else if (wr_b_ok && (WA_B == ADDR_W'(i))) begin
          mem[ADDR_W'(i)] <= WD_B;
        end else if (wr_a_ok && (WA_A == ADDR_W'(i))) begin
          mem[ADDR_W'(i)] <= WD_A;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic [DATA_W-1:0] rd_k;

    assign ra_k = RA[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_k = mem[ra_k];
`ifdef REG_FILE_BYPASS_EN
      if (wr_b_ok && (WA_B == ra_k))      rd_k = WD_B;
      else if (wr_a_ok && (WA_A == ra_k)) rd_k = WD_A;
`endif
      if (ra_k == ZERO) rd_k = '0;
    end

    assign RD[k*DATA_W +: DATA_W] = rd_k;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus a randomized phase,
// all checked every cycle against a behavioural register-file model.
module tb_reg_file_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [NR*AW-1:0] RA;
  logic [NR*DW-1:0] RD;
  logic             WE_A, WE_B, CLR_REQ, CLR_BUSY, CLR_DONE;
  logic [AW-1:0]    WA_A, WA_B;
  logic [DW-1:0]    WD_A, WD_B;

  logic [11:0] ra2;
  logic [63:0] rd2;
  logic        we2;
  logic [2:0]  wa2;
  logic [15:0] wd2;
  logic        busy2, done2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_clr_pos;
  bit            m_done;

  always #5 CLK = ~CLK;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .CLK(CLK), .RST(RST), .RA(RA), .RD(RD),
    .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
    .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
    .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut2 (
    .CLK(CLK), .RST(RST), .RA(ra2), .RD(rd2),
    .WE_A(we2), .WA_A(wa2), .WD_A(wd2),
    .WE_B(1'b0), .WA_B(3'd0), .WD_B(16'd0),
    .CLR_REQ(1'b0), .CLR_BUSY(busy2), .CLR_DONE(done2)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain array plus "next address to clear" (0 = not clearing).
  always @(posedge CLK or negedge RST) begin : model
    bit done_n;
    done_n = 1'b0;
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_clr_pos = 0;
    end else if (m_clr_pos != 0) begin
      m_mem[m_clr_pos] = '0;
      if (m_clr_pos == DEPTH - 1) begin
        m_clr_pos = 0;
        done_n    = 1'b1;
      end else begin
        m_clr_pos++;
      end
    end else begin
      if (WE_A && WA_A != 0) m_mem[WA_A] = WD_A;
      if (WE_B && WA_B != 0) m_mem[WA_B] = WD_B;
      if (CLR_REQ && !m_done) m_clr_pos = 1;
    end
    m_done = done_n;
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
`ifdef REG_FILE_BYPASS_EN
    if (m_clr_pos == 0) begin
      if (WE_A && WA_A == a) v = WD_A;
      if (WE_B && WA_B == a) v = WD_B;
    end
`endif
    return v;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", 32'(CLR_BUSY), 32'(m_clr_pos != 0));
      chk("done", 32'(CLR_DONE), 32'(m_done));
      for (int k = 0; k < NR; k++)
        chk($sformatf("rd%0d", k), RD[k*DW +: DW], exp_rd(RA[k*AW +: AW]));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    WE_A = 1'b0; WA_A = '0; WD_A = '0;
    WE_B = 1'b0; WA_B = '0; WD_B = '0;
    CLR_REQ = 1'b0;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    RA[k*AW +: AW] = a;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 1; i < DEPTH; i++) begin
      WE_A = 1'b1; WA_A = AW'(i); WD_A = base + DW'(i);
      cyc();
    end
    idle_in();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_n, done_n, done_seen;
    logic [15:0] e2 [4];

    idle_in();
    RA = '0; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;
    repeat (3) cyc();
    RST = 1'b1;
    chk_en = 1'b1;

    // After reset every address reads zero on both ports.
    @(negedge CLK);
    chk("rst_busy", 32'(CLR_BUSY), 32'd0);
    chk("rst_done", 32'(CLR_DONE), 32'd0);
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      set_ra(0, AW'(i)); set_ra(1, AW'(31 - i));
      @(negedge CLK);
      chk("rst_rd0", RD[31:0], 32'd0);
      chk("rst_rd1", RD[63:32], 32'd0);
      cyc();
    end

    // Writes to r0 are discarded.
    WE_A = 1'b1; WA_A = '0; WD_A = 32'hDEADBEEF;
    WE_B = 1'b1; WA_B = '0; WD_B = 32'h12345678;
    cyc();
    idle_in(); set_ra(0, '0);
    @(negedge CLK);
    chk("r0_zero", RD[31:0], 32'd0);
    cyc();

    // Same-address dual write: B wins; distinct addresses: both land.
    WE_A = 1'b1; WA_A = 5'd5; WD_A = 32'h11111111;
    WE_B = 1'b1; WA_B = 5'd5; WD_B = 32'h22222222;
    cyc();
    WE_A = 1'b1; WA_A = 5'd6; WD_A = 32'h66666666;
    WE_B = 1'b1; WA_B = 5'd8; WD_B = 32'h88888888;
    set_ra(0, 5'd5);
    @(negedge CLK);
    chk("dual_same", RD[31:0], 32'h22222222);
    cyc();
    idle_in(); set_ra(0, 5'd6); set_ra(1, 5'd8);
    @(negedge CLK);
    chk("dual_a", RD[31:0], 32'h66666666);
    chk("dual_b", RD[63:32], 32'h88888888);
    cyc();

    // Same-cycle visibility of a write.
    set_ra(0, 5'd9);
    WE_A = 1'b1; WA_A = 5'd9; WD_A = 32'hCAFE0001;
    @(negedge CLK);
`ifdef REG_FILE_BYPASS_EN
    chk("wr_same_cycle", RD[31:0], 32'hCAFE0001);
`else
    chk("wr_same_cycle", RD[31:0], 32'd0);
`endif
    cyc();
    idle_in();
    @(negedge CLK);
    chk("wr_next_cycle", RD[31:0], 32'hCAFE0001);
    cyc();

    // Narrow 4-read-port instance.
    for (int i = 1; i < 8; i++) begin
      we2 = 1'b1; wa2 = 3'(i); wd2 = 16'(i * 32'h1111);
      cyc();
    end
    we2 = 1'b0;
    ra2 = {3'd7, 3'd5, 3'd3, 3'd1};
    e2[0] = 16'h1111; e2[1] = 16'h3333; e2[2] = 16'h5555; e2[3] = 16'h7777;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) chk($sformatf("nr4_a_rd%0d", k), 32'(rd2[k*16 +: 16]), 32'(e2[k]));
    cyc();
    ra2 = {3'd0, 3'd2, 3'd4, 3'd6};
    e2[0] = 16'h6666; e2[1] = 16'h4444; e2[2] = 16'h2222; e2[3] = 16'h0000;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) chk($sformatf("nr4_b_rd%0d", k), 32'(rd2[k*16 +: 16]), 32'(e2[k]));
    chk("nr4_busy", 32'(busy2), 32'd0);
    cyc();

    // Full bulk clear with a dropped write and an ignored re-request.
    fill(32'd0);
    CLR_REQ = 1'b1;
    cyc();
    CLR_REQ = 1'b0;
    set_ra(1, 5'd7);
    busy_n = 0; done_n = 0;
    for (int n = 0; n < 40; n++) begin
      case (n)
        2:  begin WE_A = 1'b1; WA_A = 5'd7; WD_A = 32'h77777777; end
        3:  idle_in();
        10: CLR_REQ = 1'b1;
        11: CLR_REQ = 1'b0;
        24: begin WE_B = 1'b1; WA_B = 5'd20; WD_B = 32'hAAAAAAAA; set_ra(1, 5'd20); end
        25: idle_in();
        default: ;
      endcase
      @(negedge CLK);
      if (CLR_BUSY) busy_n++;
      if (CLR_DONE) done_n++;
      if (n == 4)  chk("mid_clr_r7_old", RD[63:32], 32'd7);
      if (n == 26) chk("mid_clr_r20_dropped", RD[63:32], 32'd0);
      cyc();
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd31);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      set_ra(0, AW'(i));
      @(negedge CLK);
      chk("post_clr_zero", RD[31:0], 32'd0);
      cyc();
    end

    // Reset in the middle of a clear aborts it without a done pulse.
    fill(32'h100);
    CLR_REQ = 1'b1;
    cyc();
    CLR_REQ = 1'b0;
    repeat (10) cyc();
    set_ra(0, 5'd25); set_ra(1, 5'd2);
    RST = 1'b0;
    #1;
    chk("abort_busy", 32'(CLR_BUSY), 32'd0);
    chk("abort_r25", RD[31:0], 32'd0);
    cyc();
    RST = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (CLR_DONE) done_seen++;
      cyc();
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    WE_A = 1'b1; WA_A = 5'd3; WD_A = 32'h33333333;
    cyc();
    idle_in(); set_ra(0, 5'd3);
    @(negedge CLK);
    chk("post_abort_wr", RD[31:0], 32'h33333333);
    cyc();

    // Randomized traffic with small-address bias to force collisions.
    for (int c = 0; c < 3000; c++) begin
      WE_A = 1'($urandom_range(0, 1));
      WE_B = 1'($urandom_range(0, 1));
      WA_A = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      WA_B = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      WD_A = $urandom;
      WD_B = $urandom;
      set_ra(0, ($urandom_range(0, 3) == 0) ? WA_A : AW'($urandom));
      set_ra(1, ($urandom_range(0, 3) == 0) ? WA_B : AW'($urandom));
      CLR_REQ = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 999) == 0) begin
        idle_in();
        RST = 1'b0;
        cyc();
        RST = 1'b1;
      end else begin
        cyc();
      end
    end

    idle_in();
    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
